// File: rtl/freq_ratio_meter.sv
// freq_ratio_meter: measures period and high time of div_in in clk cycles, with lock and overflow flags
module freq_ratio_meter #(
    parameter int CNT_W  = 8,
    parameter int LOCK_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             div_in,
    output logic [CNT_W-1:0] ratio,
    output logic [CNT_W-1:0] high_cnt,
    output logic             valid,
    output logic             locked,
    output logic             ovf
);
    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;
    localparam logic [CNT_W-1:0] MAX  = '1;
    localparam logic [CNT_W-1:0] ONE  = 1;
    localparam logic [3:0]       LOCK = 4'(LOCK_N);
    state_t           r_state, w_next;
    logic             r_div_q, r_valid, r_locked, r_ovf;
    logic [CNT_W-1:0] r_period, r_high, r_ratio, r_high_cnt;
    logic [3:0]       r_match, w_match;
    logic             w_edge, w_ovf_hit;
    assign w_edge    = div_in & ~r_div_q;
    assign w_ovf_hit = (r_state == MEAS) && !w_edge && (r_period == MAX);
    assign w_match   = (r_period == r_ratio && r_ratio != '0) ?
                       ((r_match == LOCK) ? r_match : r_match + 4'd1) : 4'd1;
    assign ratio     = r_ratio;
    assign high_cnt  = r_high_cnt;
    assign valid     = r_valid;
    assign locked    = r_locked;
    assign ovf       = r_ovf;
    // next state: start low forces IDLE, overflow falls back to ARM
    always_comb begin
        w_next = !start ? IDLE :
                 (r_state == IDLE) ? ARM :
                 (r_state == ARM && w_edge) ? MEAS :
                 w_ovf_hit ? ARM : r_state;
    end
    // state register
    always_ff @(posedge clk) begin
        r_state <= rst ? IDLE : w_next;
    end
    // edge detect, period/high-time accumulation, result capture, lock and overflow tracking
    always_ff @(posedge clk) begin
        if (rst || !start) begin
            r_div_q    <= 1'b0;
            r_valid    <= 1'b0;
            r_locked   <= 1'b0;
            r_ovf      <= 1'b0;
            r_period   <= '0;
            r_high     <= '0;
            r_ratio    <= '0;
            r_high_cnt <= '0;
            r_match    <= '0;
        end else begin
            r_div_q <= div_in;
            r_valid <= 1'b0;
            if (r_state == ARM && w_edge) begin
                r_period <= ONE;
                r_high   <= ONE;
            end else if (r_state == MEAS) begin
                if (w_edge) begin
                    r_ratio    <= r_period;
                    r_high_cnt <= r_high;
                    r_valid    <= 1'b1;
                    r_period   <= ONE;
                    r_high     <= ONE;
                    r_match    <= w_match;
                    r_locked   <= (w_match == LOCK);
                end else if (r_period == MAX) begin
                    r_ovf    <= 1'b1;
                    r_locked <= 1'b0;
                    r_match  <= '0;
                end else begin
                    r_period <= r_period + ONE;
                    r_high   <= r_high + CNT_W'(div_in);
                end
            end
        end
    end
endmodule

// File: tb/tb_freq_ratio_meter.sv
// tb_freq_ratio_meter: directed stimulus against an edge-timestamp reference model plus literal checks
module tb_freq_ratio_meter;
    localparam int LOCK_N = 4;
    localparam int OVF_GAP = 255;
    logic clk = 1'b0, rst, start, div_in;
    logic [7:0] ratio, high_cnt;
    logic valid, locked, ovf;
    int errors = 0, checks = 0;
    freq_ratio_meter #(.CNT_W(8), .LOCK_N(LOCK_N)) dut (
        .clk(clk), .rst(rst), .start(start), .div_in(div_in),
        .ratio(ratio), .high_cnt(high_cnt), .valid(valid), .locked(locked), .ovf(ovf)
    );
    always #5 clk = ~clk;
    // reference model: timestamps of rising edges and an input history
    bit hist [0:8191];
    int t = 0, t_last = 0, m_mode = 0;
    bit m_prev = 0, m_edge, cmp_on = 0;
    int e_ratio = 0, e_high = 0;
    bit e_valid = 0, e_locked = 0, e_ovf = 0;
    int rq[$];
    function automatic bit run_ok();
        if (rq.size() < LOCK_N) return 0;
        for (int i = rq.size() - LOCK_N; i < rq.size(); i++)
            if (rq[i] != rq[rq.size()-1]) return 0;
        return 1;
    endfunction
    always @(posedge clk) begin
        if (rst || !start) begin
            m_mode = 0; m_prev = 0; e_ratio = 0; e_high = 0;
            e_valid = 0; e_locked = 0; e_ovf = 0; rq.delete();
        end else begin
            m_edge = div_in && !m_prev;
            m_prev = div_in;
            hist[t] = div_in;
            e_valid = 0;
            if (m_mode == 0) m_mode = 1;
            else if (m_mode == 1) begin
                if (m_edge) begin m_mode = 2; t_last = t; end
            end else if (m_edge) begin
                e_ratio = t - t_last;
                e_high = 0;
                for (int k = t_last; k < t; k++) e_high += int'(hist[k]);
                e_valid = 1;
                rq.push_back(e_ratio);
                e_locked = run_ok();
                t_last = t;
            end else if (t - t_last == OVF_GAP) begin
                e_ovf = 1; e_locked = 0; rq.delete(); m_mode = 1;
            end
        end
        t++;
        cmp_on = 1;
    end
    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s at t=%0d: got %0d expected %0d", n, t, a, e);
        end
    endtask
    // per-cycle compare against the model
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("ratio", {24'b0, ratio}, e_ratio);
            chk("high_cnt", {24'b0, high_cnt}, e_high);
            chk("valid", {31'b0, valid}, {31'b0, e_valid});
            chk("locked", {31'b0, locked}, {31'b0, e_locked});
            chk("ovf", {31'b0, ovf}, {31'b0, e_ovf});
        end
    end
    task automatic step(input logic r, input logic s, input logic d);
        rst = r; start = s; div_in = d;
        @(posedge clk); #1;
    endtask
    task automatic per(input int p, input int h);
        for (int i = 0; i < p; i++) step(1'b0, 1'b1, i < h);
    endtask
    task automatic lit(input string n, input logic [31:0] a, input int e);
        chk(n, a, e);
    endtask
    initial begin
        rst = 1'b1; start = 1'b0; div_in = 1'b0;
        @(posedge clk); #1;
        step(1'b1, 1'b0, 1'b0);
        lit("rst_ratio", {24'b0, ratio}, 0);
        lit("rst_valid", {31'b0, valid}, 0);
        lit("rst_locked", {31'b0, locked}, 0);
        lit("rst_ovf", {31'b0, ovf}, 0);
        repeat (5) per(3, 1);
        lit("div3_ratio", {24'b0, ratio}, 3);
        lit("div3_high", {24'b0, high_cnt}, 1);
        lit("div3_unlocked_3rd", {31'b0, locked}, 0);
        per(3, 1);
        lit("div3_locked_4th", {31'b0, locked}, 1);
        step(1'b0, 1'b0, 1'b0);
        lit("stop_ratio", {24'b0, ratio}, 0);
        lit("stop_locked", {31'b0, locked}, 0);
        repeat (6) per(5, 2);
        lit("r5_locked", {31'b0, locked}, 1);
        lit("r5_high", {24'b0, high_cnt}, 2);
        per(7, 3);
        per(5, 2);
        lit("r7_ratio", {24'b0, ratio}, 7);
        lit("r7_high", {24'b0, high_cnt}, 3);
        lit("r7_unlock", {31'b0, locked}, 0);
        repeat (3) per(5, 2);
        lit("relock_3", {31'b0, locked}, 0);
        per(5, 2);
        lit("relock_4", {31'b0, locked}, 1);
        step(1'b0, 1'b1, 1'b1);
        repeat (300) step(1'b0, 1'b1, 1'b0);
        lit("ovf_set", {31'b0, ovf}, 1);
        lit("ovf_locked", {31'b0, locked}, 0);
        lit("ovf_ratio_hold", {24'b0, ratio}, 5);
        per(4, 1);
        lit("ovf_rearm_ratio", {24'b0, ratio}, 5);
        per(4, 1);
        lit("ovf_next_ratio", {24'b0, ratio}, 4);
        lit("ovf_sticky", {31'b0, ovf}, 1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        lit("abort_ratio", {24'b0, ratio}, 0);
        lit("abort_ovf", {31'b0, ovf}, 0);
        step(1'b0, 1'b1, 1'b0);
        per(4, 1);
        lit("restart_no_valid", {24'b0, ratio}, 0);
        per(4, 1);
        lit("restart_ratio", {24'b0, ratio}, 4);
        repeat (3) per(4, 1);
        lit("r4_locked", {31'b0, locked}, 1);
        step(1'b1, 1'b1, 1'b1);
        lit("midrst_ratio", {24'b0, ratio}, 0);
        lit("midrst_high", {24'b0, high_cnt}, 0);
        lit("midrst_locked", {31'b0, locked}, 0);
        per(4, 1);
        per(4, 1);
        lit("postrst_no_valid", {24'b0, ratio}, 0);
        per(4, 1);
        lit("postrst_ratio", {24'b0, ratio}, 4);
        step(1'b0, 1'b0, 1'b0);
        repeat (6) per(2, 1);
        lit("min_ratio", {24'b0, ratio}, 2);
        lit("min_high", {24'b0, high_cnt}, 1);
        lit("min_locked", {31'b0, locked}, 1);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/freq_ratio_meter.md
FREQ_RATIO_METER -- requirements
Module: freq_ratio_meter

Interface
REQ-001 Parameter CNT_W, default 8: width of the period and high-time counters and of the ratio/high_cnt outputs.
REQ-002 Parameter LOCK_N, default 4: number of consecutive identical period measurements required to assert locked; legal range 2..15.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  measurement enable; 0 forces the idle state.
REQ-006 div_in  input  1  divided-clock signal under measurement, synchronous to clk; measured from rising edge to rising edge.
REQ-007 ratio  output  CNT_W  last measured period of div_in, in clk cycles.
REQ-008 high_cnt  output  CNT_W  number of cycles div_in was 1 within the last measured period.
REQ-009 valid  output  1  one-cycle pulse; ratio and high_cnt updated this cycle.
REQ-010 locked  output  1  LOCK_N consecutive identical ratio values measured.
REQ-011 ovf  output  1  sticky flag; a period exceeded counter range.

Function
REQ-012 The block SHALL register div_in each cycle as div_q; a rising edge is a cycle where div_in=1 and div_q=0.
REQ-013 The block SHALL implement three states: IDLE, ARM and MEAS.
REQ-014 IDLE: when start=1, go to ARM; otherwise stay. While start=0 in any state, next state is IDLE.
REQ-015 On entering IDLE, all outputs, counters and div_q SHALL clear to 0.
REQ-016 ARM: on a rising edge, set period_cnt<=1, set high_acc<=1, and go to MEAS. No valid pulse is produced.
REQ-017 MEAS non-edge cycle: period_cnt increments by 1; high_acc increments by 1 when div_in=1.
REQ-018 MEAS rising edge: ratio<=period_cnt, high_cnt<=high_acc, valid<=1, period_cnt<=1, high_acc<=1.
REQ-019 Latency: valid and the new ratio/high_cnt SHALL appear on the cycle after the rising-edge cycle.
REQ-020 For div_in with a fixed period of P clk cycles, ratio SHALL equal P. The minimum legal ratio is 2.
REQ-021 valid SHALL be 0 in every cycle other than those specified in REQ-018.
REQ-022 Lock counter match_cnt (4 bits): on each MEAS rising edge, if period_cnt equals the currently held ratio and the held ratio is nonzero, increment match_cnt, saturating at LOCK_N. Otherwise set match_cnt to 1.
REQ-023 locked SHALL be 1 when match_cnt = LOCK_N, and update in the same cycle as valid.
REQ-024 A mismatching measurement SHALL deassert locked in the same cycle that valid reports it.
REQ-025 Overflow: if period_cnt = 2^CNT_W-1 in MEAS and no rising edge occurs, set ovf<=1, clear locked and match_cnt, and go to ARM. ratio and high_cnt hold.
REQ-026 ovf SHALL clear only on rst or start=0.
REQ-027 When start falls while in MEAS, the block SHALL discard the in-progress measurement and produce no valid pulse.
REQ-028 A rising edge coincident with start's first 1 cycle (IDLE) SHALL be ignored; arming begins on the next edge.

Reset
REQ-029 rst=1 SHALL force IDLE on the next clock edge and clear to 0: ratio, high_cnt, valid, locked, ovf, div_q, period_cnt, high_acc and match_cnt.
REQ-030 rst SHALL take priority over start and div_in.
REQ-031 Reset asserted mid-measurement SHALL discard the measurement and produce no valid pulse.

Verification
REQ-032 Divide-by-3 stimulus, 33% duty (div_in 1,0,0 repeating), start=1 -> first valid at the second rising edge +1 cycle; ratio=3, high_cnt=1; locked=1 at the 4th valid.
REQ-033 Stable ratio 5, then a single period of 7, then 5 again -> locked drops with the ratio=7 valid; it reasserts after 4 further valids of 5.
REQ-034 div_in held low for 300 cycles after arming, CNT_W=8 -> ovf=1 at period_cnt=255; locked=0; the next edge re-arms with no valid; ovf stays 1.
REQ-035 start deasserted mid-period, then reasserted -> all outputs 0 on the cycle after start=0; the first edge after restart produces no valid.
REQ-036 rst pulse while locked with ratio=4 -> ratio=0, high_cnt=0, locked=0, ovf=0 on the next cycle; no valid until two edges after release.
REQ-037 Minimum period (div_in toggling 1,0) -> ratio=2, high_cnt=1, with a valid pulse every 2 cycles.
